fifo_burst_reader: RTL

Read-side client of the byte FIFO. It drains bytes with single-cycle reads, relying on the FIFO's asynchronous read data. It packs BYTES consecutive bytes into one word and presents the word on a valid/ready stream toward the consumer. It never reads an empty or locked FIFO, so the FIFO's read-while-empty pointer skip is never triggered.

---
 rtl/fifo_burst_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - byte FIFO read client packing BYTES bytes per stream word
//
// Purpose:
//   Drains a byte FIFO that has combinational read data. Each FIFO read
//   captures a byte into the next lane of the output word on the same edge
//   that pops it. A full word, or a partial word when flush is held and the
//   FIFO runs dry, is then presented on a valid/ready stream. The FIFO is
//   never read while empty or locked.
//
// Optional feature macro: FIFO_BURST_READER_STATS_EN
//   When defined, adds the stat_words and stat_bytes counter outputs.
//
// Parameters:
//   BYTES     bytes packed per output word (1..MAX_DATA)
//   MAX_DATA  depth of the attached FIFO; caps the burst start threshold
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         asynchronous reset, active-high
//   fifo_rdata  FIFO read data at the current read pointer (combinational)
//   fifo_empty  FIFO empty flag
//   fifo_count  FIFO occupancy
//   fifo_lock   FIFO lock; no reads are issued while high
//   fifo_ren    FIFO read enable, one byte popped per clk edge while high
//   flush       level; allows a partial word when fewer than BYTES remain
//   out_data    packed word, first byte read in lane 0 (bits 7:0)
//   out_keep    per-lane valid mask, contiguous from lane 0
//   out_valid   word available
//   out_ready   consumer accepts the word when out_valid && out_ready
//   stat_words  (STATS_EN) accepted word count, wraps at 16 bits
//   stat_bytes  (STATS_EN) FIFO byte read count, wraps at 16 bits

module fifo_burst_reader #(
  parameter int BYTES    = 4,
  parameter int MAX_DATA = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         fifo_rdata,
  input  logic               fifo_empty,
  input  logic [4:0]         fifo_count,
  input  logic               fifo_lock,
  output logic               fifo_ren,
  input  logic               flush,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_keep,
  output logic               out_valid,
  input  logic               out_ready
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]        stat_words,
  output logic [15:0]        stat_bytes
`endif
);

  // idx counts up to BYTES after the last capture, hence the extra bit.
  localparam int IDX_W = $clog2(BYTES) + 1;

  // A burst can never need more bytes than the FIFO can hold.
  localparam int               THRESH       = (BYTES > MAX_DATA) ? MAX_DATA : BYTES;
  localparam logic [4:0]       BURST_THRESH = 5'(THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             start_word;
  logic             flush_partial;

  // Reading is only legal while filling and the FIFO can actually supply data.
  assign fifo_ren = (state == FILL) && !fifo_empty && !fifo_lock;

  // A full burst is available, or flush asks us to take whatever is there.
  assign start_word = (fifo_count >= BURST_THRESH) ||
                      (flush && (fifo_count != 5'd0));

  // Close a partial word only once the FIFO is dry; a lock freezes everything.
  assign flush_partial = fifo_empty && !fifo_lock && flush && (idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_word) begin
            state    <= FILL;
            out_data <= '0;
            out_keep <= '0;
            idx      <= '0;
          end
        end

        FILL: begin
          if (fifo_ren) begin
            // Zero read latency: the byte under the read pointer lands in
            // its lane on the same edge that pops it.
            for (int i = 0; i < BYTES; i++) begin
              if (idx == IDX_W'(i)) begin
                out_data[8*i +: 8] <= fifo_rdata;
                out_keep[i]        <= 1'b1;
              end
            end
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end else if (flush_partial) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end

        HOLD: begin
          // Word and mask stay frozen until the consumer takes them; the
          // return through IDLE leaves one bubble cycle between words.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words <= '0;
      stat_bytes <= '0;
    end else begin
      if (out_valid && out_ready) begin
        stat_words <= stat_words + 16'd1;
      end
      if (fifo_ren) begin
        stat_bytes <= stat_bytes + 16'd1;
      end
    end
  end
`endif

endmodule
